// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs, 3-port round-robin grant, registered write ports.
// Optional WB_STATS_EN adds a saturating stall counter output (stall_cnt).
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        src_valid,
  input  logic [19:0]       src_rd,
  input  logic [4*XLEN-1:0] src_data,
  output logic [3:0]        src_ready,
  output logic [4:0]        wb_rd1,
  output logic [4:0]        wb_rd2,
  output logic [4:0]        wb_rd3,
  output logic [XLEN-1:0]   wb_data1,
  output logic [XLEN-1:0]   wb_data2,
  output logic [XLEN-1:0]   wb_data3,
  output logic              wb_en1,
  output logic              wb_en2,
  output logic              wb_en3,
  output logic [31:0]       clear_mask
`ifdef WB_STATS_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      rd_mem_q   [4][DEPTH];
  logic [XLEN-1:0] data_mem_q [4][DEPTH];
  logic [AW-1:0]   wptr_q [4];
  logic [AW-1:0]   rptr_q [4];
  logic [CW-1:0]   cnt_q  [4];
  logic [1:0]      rr_ptr_q, rr_ptr_d;

  logic            push [4];
  logic            pop  [4];
  logic [4:0]      head_rd   [4];
  logic [XLEN-1:0] head_data [4];

  logic            port_gnt_d [3];
  logic [1:0]      port_src_d [3];
  logic [31:0]     clear_d;
  logic            stall_d;

  logic [4:0]      wb_rd_q   [3];
  logic [XLEN-1:0] wb_data_q [3];
  logic            wb_en_q   [3];
  logic [31:0]     clear_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head_rd[i]   = rd_mem_q[i][rptr_q[i]];
      head_data[i] = data_mem_q[i][rptr_q[i]];
      src_ready[i] = (cnt_q[i] != CW'(DEPTH));
      push[i]      = src_valid[i] & src_ready[i];
    end
  end

  // Scan from rr_ptr; rd already claimed this cycle (gmask) blocks a head but not the scan.
  always_comb begin
    logic [1:0]  s;
    logic [1:0]  np;
    logic [31:0] gmask;
    np       = 2'd0;
    gmask    = '0;
    s        = 2'd0;
    stall_d  = 1'b0;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < 4; i++) pop[i] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      port_gnt_d[p] = 1'b0;
      port_src_d[p] = 2'd0;
    end
    for (int k = 0; k < 4; k++) begin
      s = rr_ptr_q + k[1:0];
      if (cnt_q[s] != '0) begin
        if (np < 2'd3 && !(head_rd[s] != 5'd0 && gmask[head_rd[s]])) begin
          pop[s]         = 1'b1;
          port_gnt_d[np] = 1'b1;
          port_src_d[np] = s;
          if (head_rd[s] != 5'd0) gmask[head_rd[s]] = 1'b1;
          rr_ptr_d       = s + 2'd1;
          np             = np + 2'd1;
        end else begin
          stall_d = 1'b1;
        end
      end
    end
    clear_d = gmask;
  end

  // Storage is written only through push, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        rd_mem_q[i][wptr_q[i]]   <= src_rd[5*i +: 5];
        data_mem_q[i][wptr_q[i]] <= src_data[XLEN*i +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      for (int p = 0; p < 3; p++) begin
        wb_rd_q[p]   <= '0;
        wb_data_q[p] <= '0;
        wb_en_q[p]   <= 1'b0;
      end
      rr_ptr_q <= 2'd0;
      clear_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
        if (pop[i])  rptr_q[i] <= rptr_q[i] + 1'b1;
        if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (!push[i] && pop[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
      for (int p = 0; p < 3; p++) begin
        if (port_gnt_d[p]) begin
          wb_rd_q[p]   <= head_rd[port_src_d[p]];
          wb_data_q[p] <= head_data[port_src_d[p]];
          wb_en_q[p]   <= (head_rd[port_src_d[p]] != 5'd0);
        end else begin
          wb_en_q[p]   <= 1'b0;
        end
      end
      rr_ptr_q <= rr_ptr_d;
      clear_q  <= clear_d;
    end
  end

`ifdef WB_STATS_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   stall_cnt_q <= '0;
    else if (stall_d && stall_cnt_q != '1)     stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign stall_cnt = stall_cnt_q;
`else
  logic stats_unused;
  assign stats_unused = stall_d;
`endif

  assign wb_rd1     = wb_rd_q[0];
  assign wb_rd2     = wb_rd_q[1];
  assign wb_rd3     = wb_rd_q[2];
  assign wb_data1   = wb_data_q[0];
  assign wb_data2   = wb_data_q[1];
  assign wb_data3   = wb_data_q[2];
  assign wb_en1     = wb_en_q[0];
  assign wb_en2     = wb_en_q[1];
  assign wb_en3     = wb_en_q[2];
  assign clear_mask = clear_q;

endmodule
